// File: rtl/nebula_pkg.sv
// nebula_pkg: shared constants, enums and instruction-field helpers for the nebula RV32I core.
// No ports; imported by nebula_core.
package nebula_pkg;

    localparam logic [31:0] RESET_ADDRESS_DEFAULT = 32'h0000_0000;

    // RV32I major opcodes (instr[6:0]).
    typedef enum logic [6:0] {
        OpcLoad    = 7'h03,
        OpcMiscMem = 7'h0f,
        OpcOpImm   = 7'h13,
        OpcAuipc   = 7'h17,
        OpcStore   = 7'h23,
        OpcOp      = 7'h33,
        OpcLui     = 7'h37,
        OpcBranch  = 7'h63,
        OpcJalr    = 7'h67,
        OpcJal     = 7'h6f,
        OpcSystem  = 7'h73
    } opcode_e;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
    } alu_op_e;

    typedef enum logic [1:0] {
        PcSeq, PcJal, PcJalr, PcBranch
    } pc_sel_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic [6:0] get_opcode(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // funct3 -> ALU op; alt selects SUB/SRA (instr[30]).
    function automatic alu_op_e alu_op_dec(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = AluAdd;
        case (f3)
            3'd0:    op = alt ? AluSub : AluAdd;
            3'd1:    op = AluSll;
            3'd2:    op = AluSlt;
            3'd3:    op = AluSltu;
            3'd4:    op = AluXor;
            3'd5:    op = alt ? AluSra : AluSrl;
            3'd6:    op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/nebula_regfile.sv
// nebula_regfile: 32x32 integer register file, x0 hardwired to zero.
// Ports: clk_i/rst_i (async active-high reset clears all registers),
//        raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o combinational reads,
//        we_i/waddr_i/wdata_i synchronous write (writes to x0 dropped),
//        raddr_c_i/rdata_c_o extra read port only with NEBULA_CORE_DEBUG_PORT_EN.
module nebula_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o,
`ifdef NEBULA_CORE_DEBUG_PORT_EN
    input  logic [4:0]  raddr_c_i,
    output logic [31:0] rdata_c_o,
`endif
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != 5'd0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
`ifdef NEBULA_CORE_DEBUG_PORT_EN
    assign rdata_c_o = (raddr_c_i == 5'd0) ? 32'd0 : regs_q[raddr_c_i];
`endif

endmodule

// File: rtl/nebula_core.sv
// nebula_core: single-cycle RV32I integer core (no data memory), CPI = 1.
// Ports: clk_i, rst_i (async active-high), icache_read_data_i (instruction at the
//        current PC, same cycle), icache_read_address_o (= PC).
// Optional macro NEBULA_CORE_DEBUG_PORT_EN adds dbg_reg_addr_i, dbg_reg_data_o,
//        dbg_retire_o and dbg_pc_o.
// LOAD/STORE/MISC-MEM/SYSTEM and illegal encodings retire as NOPs.
module nebula_core
    import nebula_pkg::*;
#(
    parameter logic [31:0] RESET_ADDRESS = RESET_ADDRESS_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] icache_read_data_i,
`ifdef NEBULA_CORE_DEBUG_PORT_EN
    input  logic [4:0]  dbg_reg_addr_i,
    output logic [31:0] dbg_reg_data_o,
    output logic        dbg_retire_o,
    output logic [31:0] dbg_pc_o,
`endif
    output logic [31:0] icache_read_address_o
);

    logic [31:0] pc_q, pc_d, pc_plus4, pc_next;
    logic [31:0] instr, rs1_data, rs2_data;
    logic [31:0] alu_a, alu_b, alu_res, wb_data;
    logic [4:0]  shamt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    opcode_e     opcode;
    alu_op_e     alu_op;
    pc_sel_e     pc_sel;
    logic        rf_we, wb_link, branch_taken;

    assign instr    = icache_read_data_i;
    assign opcode   = opcode_e'(get_opcode(instr));
    assign f3       = instr[14:12];
    assign f7       = instr[31:25];
    assign pc_plus4 = pc_q + 32'd4;

    nebula_regfile u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .raddr_a_i (instr[19:15]),
        .rdata_a_o (rs1_data),
        .raddr_b_i (instr[24:20]),
        .rdata_b_o (rs2_data),
`ifdef NEBULA_CORE_DEBUG_PORT_EN
        .raddr_c_i (dbg_reg_addr_i),
        .rdata_c_o (dbg_reg_data_o),
`endif
        .we_i      (rf_we),
        .waddr_i   (instr[11:7]),
        .wdata_i   (wb_data)
    );

    // Decode: control signals only; datapath results are combined below.
    always_comb begin
        alu_op  = AluAdd;
        alu_a   = rs1_data;
        alu_b   = rs2_data;
        rf_we   = 1'b0;
        wb_link = 1'b0;
        pc_sel  = PcSeq;
        case (opcode)
            OpcOp: begin
                if ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)))) begin
                    alu_op = alu_op_dec(f3, instr[30]);
                    rf_we  = 1'b1;
                end
            end
            OpcOpImm: begin
                alu_b  = imm_i(instr);
                // instr[30] is only an opcode bit for SRAI; elsewhere it is immediate.
                alu_op = alu_op_dec(f3, (f3 == 3'd5) && instr[30]);
                if (f3 == 3'd1) begin
                    rf_we = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    rf_we = (f7 == 7'h00) || (f7 == 7'h20);
                end else begin
                    rf_we = 1'b1;
                end
            end
            OpcLui: begin
                alu_op = AluPassB;
                alu_b  = imm_u(instr);
                rf_we  = 1'b1;
            end
            OpcAuipc: begin
                alu_a = pc_q;
                alu_b = imm_u(instr);
                rf_we = 1'b1;
            end
            OpcJal: begin
                wb_link = 1'b1;
                rf_we   = 1'b1;
                pc_sel  = PcJal;
            end
            OpcJalr: begin
                alu_b = imm_i(instr);
                if (f3 == 3'd0) begin
                    wb_link = 1'b1;
                    rf_we   = 1'b1;
                    pc_sel  = PcJalr;
                end
            end
            OpcBranch: begin
                if (branch_taken) begin
                    pc_sel = PcBranch;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (f3)
            F3_BEQ:  branch_taken = (rs1_data == rs2_data);
            F3_BNE:  branch_taken = (rs1_data != rs2_data);
            F3_BLT:  branch_taken = ($signed(rs1_data) < $signed(rs2_data));
            F3_BGE:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: branch_taken = (rs1_data < rs2_data);
            F3_BGEU: branch_taken = (rs1_data >= rs2_data);
            default: branch_taken = 1'b0;
        endcase
    end

    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            AluAdd:   alu_res = alu_a + alu_b;
            AluSub:   alu_res = alu_a - alu_b;
            AluSll:   alu_res = alu_a << shamt;
            AluSlt:   alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            AluSltu:  alu_res = {31'd0, alu_a < alu_b};
            AluXor:   alu_res = alu_a ^ alu_b;
            AluSrl:   alu_res = alu_a >> shamt;
            AluSra:   alu_res = $unsigned($signed(alu_a) >>> shamt);
            AluOr:    alu_res = alu_a | alu_b;
            AluAnd:   alu_res = alu_a & alu_b;
            AluPassB: alu_res = alu_b;
            default:  alu_res = '0;
        endcase
    end

    assign wb_data = wb_link ? pc_plus4 : alu_res;

    always_comb begin
        pc_next = pc_plus4;
        case (pc_sel)
            PcJal:    pc_next = pc_q + imm_j(instr);
            PcJalr:   pc_next = alu_res & ~32'd1;
            PcBranch: pc_next = pc_q + imm_b(instr);
            default:  pc_next = pc_plus4;
        endcase
    end

    // No misalignment trap: the low two bits are simply dropped.
    assign pc_d = {pc_next[31:2], 2'b00};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_ADDRESS;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign icache_read_address_o = pc_q;

`ifdef NEBULA_CORE_DEBUG_PORT_EN
    assign dbg_retire_o = ~rst_i;
    assign dbg_pc_o     = pc_q;
`endif

endmodule

// File: tb/tb_nebula_core.sv
// Directed bench for nebula_core. Register values are observed through the fetch
// address by jumping to them with JALR x0, imm(rs).
module tb_nebula_core;

    logic        clk;
    logic        rst;
    logic [31:0] idata;
    logic [31:0] iaddr;
    int          checks;
    int          failures;

    localparam logic [31:0] NOP = 32'h0000_0013;

    nebula_core dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .icache_read_data_i    (idata),
        .icache_read_address_o (iaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [31:0] imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'h13);
    endfunction

    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [31:0] imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'h67);
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (iaddr === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, iaddr, exp);
        end
    endtask

    // Present one instruction, let it retire, then check the next fetch address.
    task automatic step(input logic [31:0] instr, input logic [31:0] exp, input string tag);
        idata = instr;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idata    = NOP;

        // Reset hold and release
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 32'h0);
        end
        rst = 1'b0;
        #1;
        check("post_release", 32'h0);
        step(NOP, 32'h4, "seq_4");
        step(NOP, 32'h8, "seq_8");

        // ALU
        step(addi(5'd1, 5'd0, 32'd5), 32'h0c, "addi_x1");
        step(addi(5'd2, 5'd0, -32'sd3), 32'h10, "addi_x2");
        step(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h14, "add_x3");
        step(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4), 32'h18, "sub_x4");
        step(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd5), 32'h1c, "sltu_x5");
        step(enc_i(32'h401, 5'd2, 3'd5, 5'd6, 7'h13), 32'h20, "srai_x6");
        step(enc_i(32'd4, 5'd3, 3'd1, 5'd9, 7'h13), 32'h24, "slli_x9");
        step(jalr(5'd0, 5'd9, 32'd0), 32'h20, "x3_eq_2");
        step(jalr(5'd0, 5'd4, 32'd0), 32'hFFFF_FFF8, "x4_eq_fff8");
        step(enc_i(32'd6, 5'd5, 3'd1, 5'd9, 7'h13), 32'hFFFF_FFFC, "slli_x5");
        step(jalr(5'd0, 5'd9, 32'd0), 32'h40, "x5_eq_1");
        step(jalr(5'd0, 5'd6, 32'd0), 32'hFFFF_FFFC, "x6_sra");

        // Upper immediates and x0
        step(jalr(5'd0, 5'd0, 32'h0c), 32'h0c, "goto_0c");
        step({20'h12345, 5'd7, 7'h37}, 32'h10, "lui_x7");
        step({20'h00001, 5'd8, 7'h17}, 32'h14, "auipc_x8");
        step(addi(5'd0, 5'd0, 32'd9), 32'h18, "addi_x0");
        step(jalr(5'd0, 5'd7, 32'd0), 32'h1234_5000, "x7_lui");
        step(jalr(5'd0, 5'd8, 32'd0), 32'h0000_1010, "x8_auipc");
        step(jalr(5'd0, 5'd0, 32'h100), 32'h100, "x0_zero");

        // Shift amount uses only rs2[4:0]; SRL zero-fills
        step(addi(5'd10, 5'd0, 32'd33), 32'h104, "addi_x10");
        step(addi(5'd11, 5'd0, 32'd3), 32'h108, "addi_x11");
        step(enc_r(7'h00, 5'd10, 5'd11, 3'd1, 5'd12), 32'h10c, "sll_x12");
        step(enc_i(32'd4, 5'd12, 3'd1, 5'd12, 7'h13), 32'h110, "slli_x12");
        step(jalr(5'd0, 5'd12, 32'd0), 32'h60, "sll_shamt");
        step(enc_i(32'd1, 5'd2, 3'd5, 5'd13, 7'h13), 32'h64, "srli_x13");
        step(jalr(5'd0, 5'd13, 32'd0), 32'h7FFF_FFFC, "srl_zero_fill");

        // Branches
        step(addi(5'd1, 5'd0, 32'd5), 32'h8000_0000, "pc_wrap_msb");
        step(addi(5'd2, 5'd0, 32'd5), 32'h8000_0004, "addi_x2_5");
        step(jalr(5'd0, 5'd0, 32'h20), 32'h20, "goto_20");
        step(enc_b(32'd8, 5'd2, 5'd1, 3'd0), 32'h28, "beq_taken");
        step(jalr(5'd0, 5'd0, 32'h20), 32'h20, "goto_20b");
        step(enc_b(32'd8, 5'd2, 5'd1, 3'd1), 32'h24, "bne_not_taken");
        step(addi(5'd1, 5'd0, 32'd1), 32'h28, "addi_x1_1");
        step(addi(5'd2, 5'd0, -32'sd1), 32'h2c, "addi_x2_m1");
        step(enc_b(32'd8, 5'd1, 5'd2, 3'd4), 32'h34, "blt_taken");
        step(enc_b(32'd8, 5'd1, 5'd2, 3'd6), 32'h38, "bltu_not_taken");
        step(enc_b(-32'sd16, 5'd1, 5'd2, 3'd7), 32'h28, "bgeu_back");
        step(enc_b(32'd8, 5'd1, 5'd2, 3'd5), 32'h2c, "bge_not_taken");

        // Jumps
        step(jalr(5'd0, 5'd0, 32'h40), 32'h40, "goto_40");
        step(enc_j(32'd16, 5'd1), 32'h50, "jal_fwd");
        step(jalr(5'd2, 5'd1, 32'd5), 32'h48, "jalr_bit0");
        step(jalr(5'd0, 5'd2, 32'd0), 32'h54, "jalr_link");
        step(jalr(5'd1, 5'd1, 32'h10), 32'h54, "jalr_rd_rs1");
        step(jalr(5'd0, 5'd1, 32'd0), 32'h58, "rd_rs1_link");
        step(enc_j(-32'sd8, 5'd0), 32'h50, "jal_back");

        // NOP-class encodings; x1 must still hold 0x58
        step(enc_i(32'd0, 5'd0, 3'd2, 5'd1, 7'h03), 32'h54, "lw_nop");
        step({7'd0, 5'd1, 5'd0, 3'd2, 5'd0, 7'h23}, 32'h58, "sw_nop");
        step(32'h0000_0073, 32'h5c, "ecall_nop");
        step(32'h0000_000f, 32'h60, "fence_nop");
        step(32'hFFFF_FFFF, 32'h64, "illegal_nop");
        step(enc_r(7'h01, 5'd1, 5'd1, 3'd0, 5'd1), 32'h68, "mul_nop");
        step(enc_b(32'd8, 5'd1, 5'd1, 3'd2), 32'h6c, "bad_branch_nop");
        step(jalr(5'd0, 5'd1, 32'd0), 32'h58, "nop_regs_kept");

        // Mid-run reset
        idata = NOP;
        rst   = 1'b1;
        #1;
        check("midreset_async", 32'h0);
        @(posedge clk);
        #1;
        check("midreset_hold", 32'h0);
        rst = 1'b0;
        step(jalr(5'd0, 5'd1, 32'h100), 32'h100, "x1_cleared");
        step(jalr(5'd0, 5'd7, 32'h200), 32'h200, "x7_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
